// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_ex_stage: ID/EX pipeline register with load-use detection and EX       |
// | forward-select generation. Optional macro PERF_CNT_EN adds counters.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module id_ex_stage #(
  parameter int DATA_WIDTH        = 32,
  parameter int OP_WIDTH          = 5,
  parameter int FORWARD_SEL_WIDTH = 2,
  parameter int ALU_CTRL_WIDTH    = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        rd1_d,
  input  logic [DATA_WIDTH-1:0]        rd2_d,
  input  logic [OP_WIDTH-1:0]          rs_d,
  input  logic [OP_WIDTH-1:0]          rt_d,
  input  logic [OP_WIDTH-1:0]          rd_d,
  input  logic [DATA_WIDTH-1:0]        sign_extend_d,
  input  logic                         regwrite_d,
  input  logic                         memtoreg_d,
  input  logic                         memwrite_d,
  input  logic                         alu_src_d,
  input  logic                         regdst_d,
  input  logic [ALU_CTRL_WIDTH-1:0]    alu_ctrl_d,
  input  logic                         flush_e,
  input  logic                         hold_e,
  input  logic [OP_WIDTH-1:0]          write_reg_m,
  input  logic                         regwrite_m,
  input  logic [OP_WIDTH-1:0]          write_reg_w,
  input  logic                         regwrite_w,
  output logic [DATA_WIDTH-1:0]        rd1_e,
  output logic [DATA_WIDTH-1:0]        rd2_e,
  output logic [DATA_WIDTH-1:0]        sign_extend_e,
  output logic [OP_WIDTH-1:0]          rs_e,
  output logic [OP_WIDTH-1:0]          rt_e,
  output logic [OP_WIDTH-1:0]          rd_e,
  output logic                         regwrite_e,
  output logic                         memtoreg_e,
  output logic                         memwrite_e,
  output logic                         alu_src_e,
  output logic                         regdst_e,
  output logic [ALU_CTRL_WIDTH-1:0]    alu_ctrl_e,
  output logic                         valid_e,
  output logic [FORWARD_SEL_WIDTH-1:0] forward_ae,
  output logic [FORWARD_SEL_WIDTH-1:0] forward_be,
`ifdef PERF_CNT_EN
  output logic [31:0]                  bubble_cnt,
  output logic [31:0]                  stall_cnt,
`endif
  output logic                         stall_f,
  output logic                         stall_d
);

  localparam logic [FORWARD_SEL_WIDTH-1:0] c_fwd_reg = FORWARD_SEL_WIDTH'(0);
  localparam logic [FORWARD_SEL_WIDTH-1:0] c_fwd_wb  = FORWARD_SEL_WIDTH'(1);
  localparam logic [FORWARD_SEL_WIDTH-1:0] c_fwd_mem = FORWARD_SEL_WIDTH'(2);

  logic [DATA_WIDTH-1:0]     r_rd1, r_rd2, r_sext;
  logic [OP_WIDTH-1:0]       r_rs, r_rt, r_rd;
  logic                      r_regwrite, r_memtoreg, r_memwrite, r_alu_src, r_regdst, r_valid;
  logic [ALU_CTRL_WIDTH-1:0] r_alu_ctrl;
  logic                      w_load_use, w_stall, w_bubble;

  // Index 0 is hard-wired zero, so a load targeting it can never create a hazard.
  assign w_load_use = r_memtoreg & r_valid & (r_rt != '0) & ((r_rt == rs_d) | (r_rt == rt_d));
  assign w_stall    = w_load_use | hold_e;
  assign w_bubble   = ~hold_e & (flush_e | w_load_use);
  assign stall_f    = w_stall;
  assign stall_d    = w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd1 <= '0; r_rd2 <= '0; r_sext <= '0;
      r_rs <= '0; r_rt <= '0; r_rd <= '0;
      r_regwrite <= 1'b0; r_memtoreg <= 1'b0; r_memwrite <= 1'b0;
      r_alu_src <= 1'b0; r_regdst <= 1'b0; r_alu_ctrl <= '0; r_valid <= 1'b0;
    end else if (!hold_e) begin
      if (w_bubble) begin
        r_rd1 <= '0; r_rd2 <= '0; r_sext <= '0;
        r_rs <= '0; r_rt <= '0; r_rd <= '0;
        r_regwrite <= 1'b0; r_memtoreg <= 1'b0; r_memwrite <= 1'b0;
        r_alu_src <= 1'b0; r_regdst <= 1'b0; r_alu_ctrl <= '0; r_valid <= 1'b0;
      end else begin
        r_rd1 <= rd1_d; r_rd2 <= rd2_d; r_sext <= sign_extend_d;
        r_rs <= rs_d; r_rt <= rt_d; r_rd <= rd_d;
        r_regwrite <= regwrite_d; r_memtoreg <= memtoreg_d; r_memwrite <= memwrite_d;
        r_alu_src <= alu_src_d; r_regdst <= regdst_d; r_alu_ctrl <= alu_ctrl_d; r_valid <= 1'b1;
      end
    end
  end

  assign rd1_e = r_rd1;   assign rd2_e = r_rd2;   assign sign_extend_e = r_sext;
  assign rs_e = r_rs;     assign rt_e = r_rt;     assign rd_e = r_rd;
  assign regwrite_e = r_regwrite; assign memtoreg_e = r_memtoreg; assign memwrite_e = r_memwrite;
  assign alu_src_e = r_alu_src;   assign regdst_e = r_regdst;     assign alu_ctrl_e = r_alu_ctrl;
  assign valid_e = r_valid;

  // MEM result is younger than WB result, so it wins when both match.
  always_comb begin
    forward_ae = c_fwd_reg;
    if (r_rs != '0 && regwrite_m && r_rs == write_reg_m)      forward_ae = c_fwd_mem;
    else if (r_rs != '0 && regwrite_w && r_rs == write_reg_w) forward_ae = c_fwd_wb;
  end

  always_comb begin
    forward_be = c_fwd_reg;
    if (r_rt != '0 && regwrite_m && r_rt == write_reg_m)      forward_be = c_fwd_mem;
    else if (r_rt != '0 && regwrite_w && r_rt == write_reg_w) forward_be = c_fwd_wb;
  end

`ifdef PERF_CNT_EN
  logic [31:0] r_bubble_cnt, r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_bubble && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (w_stall && r_stall_cnt != '1)   r_stall_cnt  <= r_stall_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign stall_cnt  = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// Testbench for id_ex_stage: directed table, hand sequences, randomized model check.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rd1_d, rd2_d, sign_extend_d;
  logic [4:0]  rs_d, rt_d, rd_d, write_reg_m, write_reg_w;
  logic        regwrite_d, memtoreg_d, memwrite_d, alu_src_d, regdst_d;
  logic [2:0]  alu_ctrl_d;
  logic        flush_e, hold_e, regwrite_m, regwrite_w;
  logic [31:0] rd1_e, rd2_e, sign_extend_e;
  logic [4:0]  rs_e, rt_e, rd_e;
  logic        regwrite_e, memtoreg_e, memwrite_e, alu_src_e, regdst_e, valid_e;
  logic [2:0]  alu_ctrl_e;
  logic [1:0]  forward_ae, forward_be;
  logic        stall_f, stall_d;
`ifdef PERF_CNT_EN
  logic [31:0] bubble_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .sign_extend_d(sign_extend_d), .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d),
    .memwrite_d(memwrite_d), .alu_src_d(alu_src_d), .regdst_d(regdst_d), .alu_ctrl_d(alu_ctrl_d),
    .flush_e(flush_e), .hold_e(hold_e), .write_reg_m(write_reg_m), .regwrite_m(regwrite_m),
    .write_reg_w(write_reg_w), .regwrite_w(regwrite_w),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .sign_extend_e(sign_extend_e),
    .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .memwrite_e(memwrite_e), .alu_src_e(alu_src_e), .regdst_e(regdst_e), .alu_ctrl_e(alu_ctrl_e),
    .valid_e(valid_e), .forward_ae(forward_ae), .forward_be(forward_be),
`ifdef PERF_CNT_EN
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt),
`endif
    .stall_f(stall_f), .stall_d(stall_d)
  );

  // Reference model of the E slot.
  typedef struct packed {
    logic [31:0] rd1, rd2, sx;
    logic [4:0]  rs, rt, rd;
    logic        rw, mtr, mw, as, rdst;
    logic [2:0]  alu;
    logic        v;
  } e_t;

  typedef struct {
    logic [4:0] rs, rt, wm;
    logic       rm;
    logic [4:0] ww;
    logic       rw;
    logic [1:0] exp_a, exp_b;
  } fwd_vec_t;

  e_t model;
  int m_bub, m_stl;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rd1_d = '0; rd2_d = '0; sign_extend_d = '0; rs_d = '0; rt_d = '0; rd_d = '0;
    regwrite_d = 0; memtoreg_d = 0; memwrite_d = 0; alu_src_d = 0; regdst_d = 0; alu_ctrl_d = '0;
    flush_e = 0; hold_e = 0; write_reg_m = '0; regwrite_m = 0; write_reg_w = '0; regwrite_w = 0;
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] idx);
    if (idx == 0) return 2'd0;
    if (regwrite_m && idx == write_reg_m) return 2'd2;
    if (regwrite_w && idx == write_reg_w) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic model_lu();
    return model.mtr && model.v && model.rt != 0 && (model.rt == rs_d || model.rt == rt_d);
  endfunction

  function automatic e_t dut_e();
    e_t d;
    d = '{rd1_e, rd2_e, sign_extend_e, rs_e, rt_e, rd_e, regwrite_e, memtoreg_e,
          memwrite_e, alu_src_e, regdst_e, alu_ctrl_e, valid_e};
    return d;
  endfunction

  fwd_vec_t vecs[7];

  initial begin
    vecs[0] = '{5'd7,  5'd3,  5'd7,  1'b1, 5'd7,  1'b1, 2'd2, 2'd0};
    vecs[1] = '{5'd7,  5'd3,  5'd7,  1'b0, 5'd7,  1'b1, 2'd1, 2'd0};
    vecs[2] = '{5'd4,  5'd9,  5'd9,  1'b1, 5'd4,  1'b1, 2'd1, 2'd2};
    vecs[3] = '{5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 2'd0, 2'd0};
    vecs[4] = '{5'd12, 5'd12, 5'd12, 1'b0, 5'd12, 1'b0, 2'd0, 2'd0};
    vecs[5] = '{5'd31, 5'd30, 5'd30, 1'b1, 5'd31, 1'b0, 2'd0, 2'd2};
    vecs[6] = '{5'd5,  5'd5,  5'd6,  1'b1, 5'd5,  1'b1, 2'd1, 2'd1};

    clear_in();
    rst_n = 0;
    #12;
    chk("reset_e_regs", 128'(dut_e()), 128'(e_t'(0)));
    chk("reset_fwd", {forward_ae, forward_be}, 4'd0);
    chk("reset_stall", {stall_f, stall_d}, 2'd0);
`ifdef PERF_CNT_EN
    chk("reset_cnt", {bubble_cnt, stall_cnt}, 64'd0);
`endif
    rst_n = 1;
    tick();

    // Capture of operands and control, one edge of latency.
    rd1_d = 32'h11; alu_ctrl_d = 3'b010; regwrite_d = 1;
    #1;
    chk("no_comb_path_rd1", rd1_e, 32'h0);
    tick();
    chk("capture_rd1", rd1_e, 32'h11);
    chk("capture_alu", alu_ctrl_e, 3'b010);
    chk("capture_rw_valid", {regwrite_e, valid_e}, 2'b11);

    // Async reset mid-run, no edge needed.
    rst_n = 0;
    #1;
    chk("async_reset", 128'(dut_e()), 128'(e_t'(0)));
    #1 rst_n = 1;
    tick();
    chk("post_reset_capture", {valid_e, rd1_e}, {1'b1, 32'h11});

    // Forwarding table.
    for (int i = 0; i < 7; i++) begin
      clear_in();
      rs_d = vecs[i].rs; rt_d = vecs[i].rt;
      tick();
      rs_d = '0; rt_d = '0;
      write_reg_m = vecs[i].wm; regwrite_m = vecs[i].rm;
      write_reg_w = vecs[i].ww; regwrite_w = vecs[i].rw;
      #1;
      chk($sformatf("fwd_a[%0d]", i), forward_ae, vecs[i].exp_a);
      chk($sformatf("fwd_b[%0d]", i), forward_be, vecs[i].exp_b);
    end

    // Load-use: lw $5 in E, consumer rs_d=5.
    clear_in();
    memtoreg_d = 1; rt_d = 5; regwrite_d = 1;
    tick();
    clear_in();
    rs_d = 5; rt_d = 6; regwrite_d = 1;
    #1;
    chk("lu_stall", {stall_f, stall_d}, 2'b11);
    tick();
    chk("lu_bubble", {valid_e, regwrite_e, rt_e}, 7'd0);
    chk("lu_stall_drop", stall_d, 1'b0);
    tick();
    chk("lu_consumer_in", {valid_e, rs_e}, {1'b1, 5'd5});

    // Load to register 0 never stalls.
    clear_in();
    memtoreg_d = 1; rt_d = 0;
    tick();
    clear_in();
    write_reg_m = 0; regwrite_m = 1;
    #1;
    chk("r0_no_fwd", forward_be, 2'd0);
    chk("r0_no_stall", stall_d, 1'b0);

    // Hold beats flush, then flush bubbles.
    clear_in();
    rd1_d = 32'hAA;
    tick();
`ifdef PERF_CNT_EN
    m_bub = int'(bubble_cnt);
`endif
    rd1_d = 32'hBB; hold_e = 1; flush_e = 1;
    #1;
    chk("hold_stall_f", stall_f, 1'b1);
    tick();
    chk("hold_keeps", {valid_e, rd1_e}, {1'b1, 32'hAA});
    hold_e = 0;
    tick();
    chk("flush_bubble", {valid_e, rd1_e}, 33'd0);
`ifdef PERF_CNT_EN
    chk("flush_bubble_cnt", bubble_cnt, 32'(m_bub + 1));
`endif

    // Randomized run against the model.
    clear_in();
    rst_n = 0;
    #1 rst_n = 1;
    model = '0; m_bub = 0; m_stl = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rd1_d = $urandom; rd2_d = $urandom; sign_extend_d = $urandom;
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3)); rd_d = 5'($urandom);
      regwrite_d = 1'($urandom); memtoreg_d = 1'($urandom); memwrite_d = 1'($urandom);
      alu_src_d = 1'($urandom); regdst_d = 1'($urandom); alu_ctrl_d = 3'($urandom);
      hold_e = ($urandom_range(0, 7) == 0); flush_e = ($urandom_range(0, 7) == 0);
      write_reg_m = 5'($urandom_range(0, 3)); regwrite_m = 1'($urandom);
      write_reg_w = 5'($urandom_range(0, 3)); regwrite_w = 1'($urandom);
      #1;
      chk("rnd_e", 128'(dut_e()), 128'(model));
      chk("rnd_fwd_a", forward_ae, fwd(model.rs));
      chk("rnd_fwd_b", forward_be, fwd(model.rt));
      chk("rnd_stall", {stall_f, stall_d}, {2{model_lu() | hold_e}});
`ifdef PERF_CNT_EN
      chk("rnd_cnt", {bubble_cnt, stall_cnt}, {32'(m_bub), 32'(m_stl)});
`endif
      if (model_lu() || hold_e) m_stl++;
      if (!hold_e) begin
        if (flush_e || model_lu()) begin
          model = '0;
          m_bub++;
        end else begin
          model = '{rd1_d, rd2_d, sign_extend_d, rs_d, rt_d, rd_d, regwrite_d, memtoreg_d,
                    memwrite_d, alu_src_d, regdst_d, alu_ctrl_d, 1'b1};
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
